chip8_rom_loader: RTL and testbench
===================================

# chip8_rom_loader

Boot-time loader between the board's reset/control logic and `memory_controller`. On a `load` pulse it writes the CHIP-8/SCHIP font set into RAM at 0x000, then copies the game image from the flash region into RAM at 0x200, one byte at a time, over the controller's read/write/busy handshake. When the copy finishes it raises `start` to `chip8_core`. While it is active it owns the memory bus through `owns_bus`.

## Interface
- `SRC_BASE`, default 26'h2000000: flash address of image byte 0. Bit 25 selects the flash region in the memory map.
- `DST_BASE`, default 26'h0000200: RAM address of image byte 0.
- `ROM_BYTES`, default 3584: image length in bytes, range 0..3584.
- `clk_100mhz`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load`  in  1  one-cycle request to start loading.
- `mem_read`  out  1  one-cycle read request to `memory_controller`.
- `mem_write`  out  1  one-cycle write request.
- `mem_address`  out  26  request address.
- `mem_write_data`  out  16  {8'h00, byte}.
- `mem_read_data`  in  16  only [7:0] is used; valid in the cycle `mem_busy` is seen low after a read.
- `mem_busy`  in  1  controller busy.
- `owns_bus`  out  1  high in every state except IDLE and DONE; the external mux selects the loader when high.
- `loading`  out  1  same as `owns_bus`; drives the status LED.
- `start`  out  1  level, high only in DONE; drives `chip8_core.start`.
- `byte_count`  out  12  image bytes written so far.

## Operation
- States: IDLE, FONT_REQ, FONT_WAIT, ROM_RD_REQ, ROM_RD_WAIT, ROM_WR_REQ, ROM_WR_WAIT, DONE.
- IDLE or DONE with `load`=1:
  - clear the font index and `byte_count`;
  - drop `start`;
  - go to FONT_REQ.
- FONT_REQ: wait for `mem_busy`=0, then pulse `mem_write` for one cycle with address FONT_BASE+idx and data `chip8_font_rom[idx]`. Go to FONT_WAIT.
- FONT_WAIT: ignore `mem_busy` in the first cycle. Leave once `mem_busy`=0, then:
  - idx++ and back to FONT_REQ while idx < FONT_BYTES-1;
  - otherwise go to ROM_RD_REQ if ROM_BYTES>0, else to DONE.
- ROM_RD_REQ: pulse `mem_read` with address SRC_BASE+`byte_count`. Go to ROM_RD_WAIT.
- ROM_RD_WAIT: ignore the first cycle. When `mem_busy`=0, latch `mem_read_data[7:0]` into the data register and go to ROM_WR_REQ.
- ROM_WR_REQ: pulse `mem_write` with address DST_BASE+`byte_count` and the latched byte. Go to ROM_WR_WAIT.
- ROM_WR_WAIT: when `mem_busy`=0, increment `byte_count`. Go to DONE if `byte_count`+1 == ROM_BYTES, else back to ROM_RD_REQ.
- DONE: hold `start`=1 and `owns_bus`=0 until the next `load` or `rst`.
- `load` in any non-IDLE, non-DONE state is ignored.
- Address arithmetic is 26-bit; `byte_count` is zero-extended before the add. No wrap is possible within the legal ROM_BYTES range.

## Timing
- All outputs are 0 in reset; the state returns to IDLE.
- `rst` mid-load aborts immediately: request strobes drop, and RAM is left partially written.
- Request strobes are exactly one cycle wide and are never issued while `mem_busy`=1.
- Per byte, excluding controller busy time:
  - font: 3 cycles (REQ, ignored WAIT cycle, exit cycle);
  - image: 6 cycles (read plus write).
- `start` rises one cycle after the final ROM_WR_WAIT exit, or after the final FONT_WAIT exit when ROM_BYTES=0.
- `mem_address` and `mem_write_data` are registered and stable from the request cycle until the following WAIT exit.

## Structure
- `chip8_pkg` holds:
  - FONT_BASE=0, FONT_BYTES=240 (80 small + 160 big glyphs);
  - PROGRAM_BASE='h200;
  - MEM_ADDR_W=26;
  - the state encoding.
- Sub-module `chip8_font_rom`: asynchronous read, 8-bit index in, 8-bit glyph byte out. The CHIP-8 hex digits occupy 0..79 and the SCHIP 10-byte digits occupy 80..239.

## Test plan
- Reset, pulse `load` with the sram_model behind `memory_controller`, ROM_BYTES=4, flash bytes 12 34 56 78 → RAM[0x000]=F0, RAM[0x04F]=80 (last byte of "F"), RAM[0x200..0x203]=12 34 56 78, `byte_count`=4, `start`=1.
- ROM_BYTES=0, pulse `load` → 240 font writes, no `mem_read` pulses, `start` rises one cycle after the last font write completes.
- Second `load` pulse while in ROM_RD_WAIT → ignored: the write count still totals 240+N and `start` rises once.
- `rst` asserted after 2 image bytes → all outputs 0 within the same cycle; a subsequent `load` reloads completely and RAM[0x200..] matches flash.
- Hold `mem_busy`=1 for 20 extra cycles on every access → no strobe is issued while busy, every strobe is exactly 1 cycle wide, and the data is still correct.
- Pulse `load` again from DONE → `start` drops the next cycle, `owns_bus`=1, and the load repeats identically.

Source files
------------

// File: rtl/chip8_pkg.sv
// Shared constants and state encoding for the CHIP-8 boot loader.
// Holds memory-map constants, font geometry and the loader FSM states.
package chip8_pkg;

    localparam int MEM_ADDR_W = 26;

    localparam logic [MEM_ADDR_W-1:0] FONT_BASE    = 26'h0000000;
    localparam logic [MEM_ADDR_W-1:0] PROGRAM_BASE = 26'h0000200;

    // 16 small glyphs x 5 bytes + 16 big glyphs x 10 bytes
    localparam int         FONT_BYTES = 240;
    localparam logic [7:0] FONT_LAST  = 8'(FONT_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FONT_REQ,
        S_FONT_WAIT,
        S_ROM_RD_REQ,
        S_ROM_RD_WAIT,
        S_ROM_WR_REQ,
        S_ROM_WR_WAIT,
        S_DONE
    } ld_state_t;

endpackage

// File: rtl/chip8_font_rom.sv
// Glyph ROM: CHIP-8 hex digits at 0..79, SCHIP 8x10 digits at 80..239.
// Ports: i_idx (byte index), o_data (glyph byte, async read; 0 past end).
module chip8_font_rom
    import chip8_pkg::*;
(
    input  logic [7:0] i_idx,
    output logic [7:0] o_data
);

    localparam logic [7:0] FONT [0:FONT_BYTES-1] = '{
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0, 8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0, 8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10, 8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0, 8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0, 8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90, 8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0, 8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0, 8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80,
        8'h3C, 8'h7E, 8'hE7, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hE7, 8'h7E, 8'h3C,
        8'h18, 8'h38, 8'h58, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h3C,
        8'h3E, 8'h7F, 8'hC3, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hFF, 8'hFF,
        8'h3C, 8'h7E, 8'hC3, 8'h03, 8'h0E, 8'h0E, 8'h03, 8'hC3, 8'h7E, 8'h3C,
        8'h06, 8'h0E, 8'h1E, 8'h36, 8'h66, 8'hC6, 8'hFF, 8'hFF, 8'h06, 8'h06,
        8'hFF, 8'hFF, 8'hC0, 8'hC0, 8'hFC, 8'hFE, 8'h03, 8'hC3, 8'h7E, 8'h3C,
        8'h3E, 8'h7C, 8'hE0, 8'hC0, 8'hFC, 8'hFE, 8'hC3, 8'hC3, 8'h7E, 8'h3C,
        8'hFF, 8'hFF, 8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'h60, 8'h60,
        8'h3C, 8'h7E, 8'hC3, 8'hC3, 8'h7E, 8'h7E, 8'hC3, 8'hC3, 8'h7E, 8'h3C,
        8'h3C, 8'h7E, 8'hC3, 8'hC3, 8'h7F, 8'h3F, 8'h03, 8'h03, 8'h3E, 8'h7C,
        8'h7E, 8'hFF, 8'hC3, 8'hC3, 8'hC3, 8'hFF, 8'hFF, 8'hC3, 8'hC3, 8'hC3,
        8'hFC, 8'hFC, 8'hC3, 8'hC3, 8'hFC, 8'hFC, 8'hC3, 8'hC3, 8'hFC, 8'hFC,
        8'h3C, 8'hFF, 8'hC3, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC3, 8'hFF, 8'h3C,
        8'hFC, 8'hFE, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hFE, 8'hFC,
        8'hFF, 8'hFF, 8'hC0, 8'hC0, 8'hFF, 8'hFF, 8'hC0, 8'hC0, 8'hFF, 8'hFF,
        8'hFF, 8'hFF, 8'hC0, 8'hC0, 8'hFF, 8'hFF, 8'hC0, 8'hC0, 8'hC0, 8'hC0
    };

    always_comb begin
        o_data = 8'h00;
        if (i_idx <= FONT_LAST) begin
            o_data = FONT[i_idx];
        end
    end

endmodule

// File: rtl/chip8_rom_loader.sv
// Boot loader: writes the font to RAM, then copies the flash image to RAM.
// Ports: clk_100mhz/rst, load pulse in, memory_controller request/busy
// handshake, owns_bus/loading while active, start level, byte_count.
module chip8_rom_loader
    import chip8_pkg::*;
#(
    parameter logic [MEM_ADDR_W-1:0] SRC_BASE  = 26'h2000000,
    parameter logic [MEM_ADDR_W-1:0] DST_BASE  = 26'h0000200,
    parameter int                    ROM_BYTES = 3584
) (
    input  logic                  clk_100mhz,
    input  logic                  rst,
    input  logic                  load,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [MEM_ADDR_W-1:0] mem_address,
    output logic [15:0]           mem_write_data,
    input  logic [15:0]           mem_read_data,
    input  logic                  mem_busy,
    output logic                  owns_bus,
    output logic                  loading,
    output logic                  start,
    output logic [11:0]           byte_count
);

    localparam logic [11:0] ROM_LEN = 12'(ROM_BYTES);

    ld_state_t             r_state;
    ld_state_t             w_next;
    logic [7:0]            r_idx;
    logic [11:0]           r_count;
    logic [MEM_ADDR_W-1:0] r_addr;
    logic [15:0]           r_wdata;
    logic                  r_first;

    logic [7:0]            w_idx_nx;
    logic [11:0]           w_count_nx;
    logic [11:0]           w_count_inc;
    logic [MEM_ADDR_W-1:0] w_addr_nx;
    logic [15:0]           w_wdata_nx;
    logic [7:0]            w_font_idx;
    logic [7:0]            w_font_byte;
    logic                  w_unused;

    assign w_unused = ^mem_read_data[15:8];

    // Index of the glyph byte for the next font request, so its
    // address/data can be registered on the way into FONT_REQ.
    assign w_font_idx  = (r_state == S_FONT_WAIT) ? r_idx + 8'd1 : 8'd0;
    assign w_count_inc = r_count + 12'd1;

    chip8_font_rom u_font (
        .i_idx  (w_font_idx),
        .o_data (w_font_byte)
    );

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_count <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_first <= 1'b0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idx_nx;
            r_count <= w_count_nx;
            r_addr  <= w_addr_nx;
            r_wdata <= w_wdata_nx;
            // the controller raises busy one cycle late, so the first
            // WAIT cycle after any strobe is not trusted
            r_first <= mem_read | mem_write;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_idx_nx   = r_idx;
        w_count_nx = r_count;
        w_addr_nx  = r_addr;
        w_wdata_nx = r_wdata;
        mem_read   = 1'b0;
        mem_write  = 1'b0;

        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (load) begin
                    w_next     = S_FONT_REQ;
                    w_idx_nx   = 8'd0;
                    w_count_nx = 12'd0;
                    w_addr_nx  = FONT_BASE + {18'd0, w_font_idx};
                    w_wdata_nx = {8'h00, w_font_byte};
                end
            end
            S_FONT_REQ: begin
                if (!mem_busy) begin
                    mem_write = 1'b1;
                    w_next    = S_FONT_WAIT;
                end
            end
            S_FONT_WAIT: begin
                if (!r_first && !mem_busy) begin
                    if (r_idx < FONT_LAST) begin
                        w_next     = S_FONT_REQ;
                        w_idx_nx   = w_font_idx;
                        w_addr_nx  = FONT_BASE + {18'd0, w_font_idx};
                        w_wdata_nx = {8'h00, w_font_byte};
                    end else if (ROM_BYTES > 0) begin
                        w_next    = S_ROM_RD_REQ;
                        w_addr_nx = SRC_BASE + {14'd0, r_count};
                    end else begin
                        w_next = S_DONE;
                    end
                end
            end
            S_ROM_RD_REQ: begin
                if (!mem_busy) begin
                    mem_read = 1'b1;
                    w_next   = S_ROM_RD_WAIT;
                end
            end
            S_ROM_RD_WAIT: begin
                if (!r_first && !mem_busy) begin
                    w_next     = S_ROM_WR_REQ;
                    w_addr_nx  = DST_BASE + {14'd0, r_count};
                    w_wdata_nx = {8'h00, mem_read_data[7:0]};
                end
            end
            S_ROM_WR_REQ: begin
                if (!mem_busy) begin
                    mem_write = 1'b1;
                    w_next    = S_ROM_WR_WAIT;
                end
            end
            S_ROM_WR_WAIT: begin
                if (!r_first && !mem_busy) begin
                    w_count_nx = w_count_inc;
                    if (w_count_inc == ROM_LEN) begin
                        w_next = S_DONE;
                    end else begin
                        w_next    = S_ROM_RD_REQ;
                        w_addr_nx = SRC_BASE + {14'd0, w_count_inc};
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign owns_bus       = (r_state != S_IDLE) && (r_state != S_DONE);
    assign loading        = owns_bus;
    assign start          = (r_state == S_DONE);
    assign mem_address    = r_addr;
    assign mem_write_data = r_wdata;
    assign byte_count     = r_count;

endmodule

// File: tb/tb_chip8_rom_loader.sv
// Scoreboard bench for chip8_rom_loader with a busy-latency memory model.
// Two instances: a 4-byte image and an empty image, sharing the bus model.
module tb_chip8_rom_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load4 = 1'b0;
    logic        load0 = 1'b0;
    logic        busy = 1'b0;
    logic [15:0] rdata = 16'h0;
    logic        sel = 1'b0;

    logic        rd4, wr4, own4, ld4, st4;
    logic        rd0, wr0, own0, ldg0, st0;
    logic [25:0] a4, a0;
    logic [15:0] d4, d0;
    logic [11:0] bc4, bc0;

    logic        m_rd, m_wr, m_own, m_ldg, m_st;
    logic [25:0] m_a;
    logic [15:0] m_d;
    logic [11:0] m_bc;

    always #5 clk = ~clk;

    chip8_rom_loader #(.ROM_BYTES(4)) dut (
        .clk_100mhz(clk), .rst(rst), .load(load4),
        .mem_read(rd4), .mem_write(wr4), .mem_address(a4),
        .mem_write_data(d4), .mem_read_data(rdata), .mem_busy(busy),
        .owns_bus(own4), .loading(ld4), .start(st4), .byte_count(bc4)
    );

    chip8_rom_loader #(.ROM_BYTES(0)) dut0 (
        .clk_100mhz(clk), .rst(rst), .load(load0),
        .mem_read(rd0), .mem_write(wr0), .mem_address(a0),
        .mem_write_data(d0), .mem_read_data(rdata), .mem_busy(busy),
        .owns_bus(own0), .loading(ldg0), .start(st0), .byte_count(bc0)
    );

    assign m_rd  = sel ? rd0  : rd4;
    assign m_wr  = sel ? wr0  : wr4;
    assign m_own = sel ? own0 : own4;
    assign m_ldg = sel ? ldg0 : ld4;
    assign m_st  = sel ? st0  : st4;
    assign m_a   = sel ? a0   : a4;
    assign m_d   = sel ? d0   : d4;
    assign m_bc  = sel ? bc0  : bc4;

    typedef struct {
        logic [25:0] a;
        logic [7:0]  d;
        bit          c;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] flash [0:3];
    logic [7:0] ram [int];
    int n_chk = 0, n_fail = 0;
    int n_wr, n_rd, n_start, cyc = 0, last_wr, start_cyc;
    int lat = 1, cnt = 0;
    bit pend = 0, prev = 0, st_prev = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // known glyph bytes: {valid, value}
    function automatic logic [8:0] fknown(input int i);
        case (i)
            0:       return {1'b1, 8'hF0};
            4:       return {1'b1, 8'hF0};
            5:       return {1'b1, 8'h20};
            9:       return {1'b1, 8'h70};
            79:      return {1'b1, 8'h80};
            80:      return {1'b1, 8'h3C};
            239:     return {1'b1, 8'hC0};
            default: return 9'h000;
        endcase
    endfunction

    task automatic push_exp(input int nb);
        logic [8:0] f;
        for (int i = 0; i < 240; i++) begin
            f = fknown(i);
            sbq.push_back('{a: 26'(i), d: f[7:0], c: f[8]});
        end
        for (int k = 0; k < nb; k++)
            sbq.push_back('{a: 26'h200 + 26'(k), d: flash[k], c: 1'b1});
    endtask

    task automatic clr();
        n_wr = 0; n_rd = 0; n_start = 0; last_wr = 0; start_cyc = 0;
    endtask

    task automatic pulse(input bit which);
        @(posedge clk); #1;
        if (which) load0 = 1'b1; else load4 = 1'b1;
        @(posedge clk); #1;
        load0 = 1'b0; load4 = 1'b0;
    endtask

    task automatic wait_start();
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (m_st) break;
        end
        #1;
        chk("start_timeout", {31'd0, m_st}, 1);
    endtask

    // busy model: busy for 'lat' cycles starting the cycle after a strobe
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst) begin
                busy = 1'b0; cnt = 0; pend = 0;
            end else if (pend) begin
                busy = 1'b1; cnt = lat; pend = 0;
            end else if (cnt > 0) begin
                cnt--;
                busy = (cnt > 0);
            end
        end
    end

    // request monitor and scoreboard checker
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 0;
                continue;
            end
            if (m_rd || m_wr) begin
                chk("req_while_busy", {31'd0, busy}, 0);
                chk("req_width", {31'd0, prev}, 0);
                pend = 1;
            end
            prev = m_rd | m_wr;
            if (m_wr) begin
                n_wr++;
                last_wr = cyc;
                ram[int'(m_a)] = m_d[7:0];
                if (sbq.size() == 0) begin
                    chk("sb_extra_write", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("wr_addr", {6'd0, m_a}, {6'd0, e.a});
                    chk("wr_hi", {16'd0, m_d}, {24'd0, m_d[7:0]});
                    if (e.c) chk("wr_data", {24'd0, m_d[7:0]}, {24'd0, e.d});
                end
            end
            if (m_rd) begin
                chk("rd_addr", {6'd0, m_a}, 32'h2000000 + n_rd);
                rdata = {8'hEE, flash[m_a[1:0]]};
                n_rd++;
            end
            if (m_st && !st_prev) begin
                n_start++;
                start_cyc = cyc;
            end
            st_prev = m_st;
        end
    end

    initial begin
        flash[0] = 8'h12; flash[1] = 8'h34;
        flash[2] = 8'h56; flash[3] = 8'h78;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_read", {31'd0, m_rd}, 0);
        chk("rst_write", {31'd0, m_wr}, 0);
        chk("rst_owns", {31'd0, m_own}, 0);
        chk("rst_start", {31'd0, m_st}, 0);
        chk("rst_addr", {6'd0, m_a}, 0);
        chk("rst_count", {20'd0, m_bc}, 0);
        rst = 1'b0;

        // basic 4-byte load
        clr();
        push_exp(4);
        pulse(0);
        chk("owns_busy", {31'd0, m_own}, 1);
        chk("loading", {31'd0, m_ldg}, 1);
        wait_start();
        chk("count_4", {20'd0, m_bc}, 4);
        chk("owns_done", {31'd0, m_own}, 0);
        chk("ram_000", {24'd0, ram[0]}, 32'hF0);
        chk("ram_04f", {24'd0, ram[32'h4F]}, 32'h80);
        for (int k = 0; k < 4; k++)
            chk("ram_img", {24'd0, ram[32'h200 + k]}, {24'd0, flash[k]});
        chk("writes", n_wr, 244);
        chk("reads", n_rd, 4);
        chk("sb_left", sbq.size(), 0);
        chk("start_lat", start_cyc - last_wr, 3);

        // reload from DONE, extra load while in ROM_RD_WAIT
        clr();
        ram.delete();
        push_exp(4);
        pulse(0);
        #4;
        chk("reload_start", {31'd0, m_st}, 0);
        chk("reload_owns", {31'd0, m_own}, 1);
        for (int i = 0; i < 5000 && n_rd == 0; i++) begin
            @(negedge clk); #1;
        end
        chk("rd_seen", n_rd, 1);
        pulse(0);
        wait_start();
        chk("re_writes", n_wr, 244);
        chk("re_starts", n_start, 1);
        chk("re_sb_left", sbq.size(), 0);
        chk("re_count", {20'd0, m_bc}, 4);
        for (int k = 0; k < 4; k++)
            chk("re_ram", {24'd0, ram[32'h200 + k]}, {24'd0, flash[k]});

        // reset after two image bytes, then slow reload
        flash[0] = 8'hA5; flash[1] = 8'h5A;
        flash[2] = 8'hC3; flash[3] = 8'h3C;
        clr();
        push_exp(4);
        pulse(0);
        for (int i = 0; i < 5000 && n_wr < 242; i++) begin
            @(negedge clk); #1;
        end
        chk("two_bytes", n_wr, 242);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("ab_read", {31'd0, m_rd}, 0);
        chk("ab_write", {31'd0, m_wr}, 0);
        chk("ab_owns", {31'd0, m_own}, 0);
        chk("ab_start", {31'd0, m_st}, 0);
        chk("ab_count", {20'd0, m_bc}, 0);
        chk("ab_addr", {6'd0, m_a}, 0);
        sbq.delete();
        ram.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        lat = 21;
        clr();
        push_exp(4);
        pulse(0);
        wait_start();
        chk("sl_writes", n_wr, 244);
        chk("sl_count", {20'd0, m_bc}, 4);
        chk("sl_sb_left", sbq.size(), 0);
        chk("sl_font0", {24'd0, ram[0]}, 32'hF0);
        for (int k = 0; k < 4; k++)
            chk("sl_ram", {24'd0, ram[32'h200 + k]}, {24'd0, flash[k]});

        // empty image: font only
        lat = 1;
        repeat (30) @(posedge clk);
        sel = 1'b1;
        clr();
        push_exp(0);
        pulse(1);
        wait_start();
        chk("e_writes", n_wr, 240);
        chk("e_reads", n_rd, 0);
        chk("e_start_lat", start_cyc - last_wr, 3);
        chk("e_count", {20'd0, m_bc}, 0);
        chk("e_sb_left", sbq.size(), 0);
        chk("e_owns", {31'd0, m_own}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
